// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage directly upstream of decode. It walks sequential
// word-aligned PCs, issues in-order requests to instruction memory, remembers
// the PC of every accepted request in a tag queue, and stores returned
// instructions with their PCs in a small FIFO that feeds decode over a
// valid/ready handshake. A redirect from execute flushes the FIFO and turns
// every request still in flight into a response that must be thrown away.
//
// Parameters
//   RESET_PC  PC of the first fetch after reset (bits [1:0] must be 0)
//   DEPTH     FIFO entries, and the cap on in-flight + buffered instructions
//             (power of 2, >= 2)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   fetch address (word aligned)
//   imem_rsp_valid  response valid (in order, at most one per cycle)
//   imem_rsp_inst   returned instruction word
//   redirect_valid  branch/jump redirect from execute
//   redirect_pc     redirect target (low two bits are ignored)
//   id_valid        id_inst/id_pc hold a valid instruction
//   id_ready        decode accepts the instruction
//   id_inst         instruction to decode (NOP when the FIFO is empty)
//   id_pc           PC of id_inst (0 when the FIFO is empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int unsigned    PTR_W     = $clog2(DEPTH);
  localparam int unsigned    CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);
  localparam logic [31:0]    NOP_INST  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  // Control state
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] outstanding;   // requests accepted, response not yet seen
  logic [CNT_W-1:0] drop_cnt;      // in-flight responses to discard
  logic [CNT_W-1:0] buf_count;
  logic [PTR_W-1:0] tag_wr_ptr;
  logic [PTR_W-1:0] tag_rd_ptr;
  logic [PTR_W-1:0] buf_wr_ptr;
  logic [PTR_W-1:0] buf_rd_ptr;

  // Storage
  logic [31:0] tag_mem [DEPTH];
  entry_t      buf_mem [DEPTH];

  // Per-cycle events
  logic credit_ok;
  logic req_fire;
  logic rsp_take;
  logic rsp_keep;
  logic id_fire;

  // NOTE: every signal driven here gets a value on every path through the
  // block; leaving one unassigned on some path would infer a latch.
  always_comb begin
    // Responses and pops landing this cycle are deliberately not credited,
    // which keeps the request path free of the memory/decode inputs.
    credit_ok      = ({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_LIM;
    imem_req_valid = !rst && !redirect_valid && credit_ok && (drop_cnt == '0);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is illegal and simply ignored.
    rsp_take       = imem_rsp_valid && (outstanding != '0);
    rsp_keep       = rsp_take && (drop_cnt == '0) && !redirect_valid;

    id_valid       = !rst && (buf_count != '0);
    id_fire        = id_valid && id_ready;
    id_inst        = id_valid ? buf_mem[buf_rd_ptr].inst : NOP_INST;
    id_pc          = id_valid ? buf_mem[buf_rd_ptr].pc   : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_count   <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      buf_wr_ptr  <= '0;
      buf_rd_ptr  <= '0;
    end else begin
      // The tag queue tracks the memory, not the FIFO: it pops on every
      // response, dropped or kept, so tags and drop_cnt stay in step.
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
      if (req_fire) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (rsp_take) tag_rd_ptr <= tag_rd_ptr + 1'b1;

      if (redirect_valid) begin
        // No request fires in a redirect cycle, so everything still in
        // flight after this edge is stale.
        fetch_pc   <= redirect_pc & 32'hFFFF_FFFC;
        drop_cnt   <= outstanding - CNT_W'(rsp_take);
        buf_count  <= '0;
        buf_wr_ptr <= '0;
        buf_rd_ptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (rsp_keep) buf_wr_ptr <= buf_wr_ptr + 1'b1;
        if (id_fire)  buf_rd_ptr <= buf_rd_ptr + 1'b1;
        buf_count <= buf_count + CNT_W'(rsp_keep) - CNT_W'(id_fire);
      end
    end
  end

  // NOTE: the storage arrays are not reset; the pointers and counts above
  // decide which entries are meaningful, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_ptr] <= fetch_pc;
    if (rsp_keep) buf_mem[buf_wr_ptr] <= '{inst: imem_rsp_inst, pc: tag_mem[tag_rd_ptr]};
  end

  // A response must always belong to an accepted request.
  rsp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(imem_rsp_valid && (outstanding == '0))
  );

endmodule
